// File: rtl/wb_to_bus_bridge_if.sv
// wb_to_bus_bridge_if
//   Bundles the Wishbone classic slave port and the copperv split-bus master
//   port of wb_to_bus_bridge.
//
//   Modports:
//     slave  - the bridge's view: it is the Wishbone slave and drives the
//              copperv request channels (address/write payload, valids) and
//              the response-side readies.
//     master - the environment's view: the Wishbone initiator plus the
//              copperv target.
//
//   Optional feature macro: WB_ERR_EN adds the wb_err signal.
//
//   Signals:
//     wb_adr/wb_datwr/wb_we/wb_stb/wb_cyc/wb_sel : Wishbone request
//     wb_datrd/wb_ack (/wb_err)                    : Wishbone completion
//     bus_r_addr_*                                 : copperv read address channel
//     bus_r_data_*                                 : copperv read data channel
//     bus_w_data_addr_*, bus_w_data/addr/strobe    : copperv write request
//     bus_w_resp_*                                 : copperv write response
interface wb_to_bus_bridge_if #(
  parameter int unsigned addr_width   = 32,
  parameter int unsigned data_width   = 32,
  parameter int unsigned strobe_width = data_width / 8,
  parameter int unsigned resp_width   = 1
);

  // Wishbone side
  logic [addr_width-1:0]   wb_adr;
  logic [data_width-1:0]   wb_datwr;
  logic [data_width-1:0]   wb_datrd;
  logic                    wb_we;
  logic                    wb_stb;
  logic                    wb_cyc;
  logic [strobe_width-1:0] wb_sel;
  logic                    wb_ack;
`ifdef WB_ERR_EN
  logic                    wb_err;
`endif

  // copperv read channels
  logic                    bus_r_addr_valid;
  logic                    bus_r_addr_ready;
  logic [addr_width-1:0]   bus_r_addr;
  logic                    bus_r_data_valid;
  logic                    bus_r_data_ready;
  logic [data_width-1:0]   bus_r_data;

  // copperv write channels
  logic                    bus_w_data_addr_valid;
  logic                    bus_w_data_addr_ready;
  logic [data_width-1:0]   bus_w_data;
  logic [addr_width-1:0]   bus_w_addr;
  logic [strobe_width-1:0] bus_w_strobe;
  logic                    bus_w_resp_valid;
  logic                    bus_w_resp_ready;
  logic [resp_width-1:0]   bus_w_resp;

  modport slave (
    input  wb_adr,
    input  wb_datwr,
    input  wb_we,
    input  wb_stb,
    input  wb_cyc,
    input  wb_sel,
    output wb_datrd,
    output wb_ack,
`ifdef WB_ERR_EN
    output wb_err,
`endif
    output bus_r_addr_valid,
    input  bus_r_addr_ready,
    output bus_r_addr,
    input  bus_r_data_valid,
    output bus_r_data_ready,
    input  bus_r_data,
    output bus_w_data_addr_valid,
    input  bus_w_data_addr_ready,
    output bus_w_data,
    output bus_w_addr,
    output bus_w_strobe,
    input  bus_w_resp_valid,
    output bus_w_resp_ready,
    input  bus_w_resp
  );

  modport master (
    output wb_adr,
    output wb_datwr,
    output wb_we,
    output wb_stb,
    output wb_cyc,
    output wb_sel,
    input  wb_datrd,
    input  wb_ack,
`ifdef WB_ERR_EN
    input  wb_err,
`endif
    input  bus_r_addr_valid,
    output bus_r_addr_ready,
    input  bus_r_addr,
    output bus_r_data_valid,
    input  bus_r_data_ready,
    output bus_r_data,
    input  bus_w_data_addr_valid,
    output bus_w_data_addr_ready,
    input  bus_w_data,
    input  bus_w_addr,
    input  bus_w_strobe,
    output bus_w_resp_valid,
    input  bus_w_resp_ready,
    output bus_w_resp
  );

endinterface

// File: rtl/wb_to_bus_bridge.sv
// wb_to_bus_bridge
//   Wishbone classic slave that turns each Wishbone cycle into one copperv
//   split-bus transaction (read address + read data, or write request + write
//   response). One transaction is outstanding at a time; requests seen while
//   busy are ignored.
//
//   Ports:
//     clock - clock
//     reset - synchronous, active-high reset
//     bus   - wb_to_bus_bridge_if.slave: Wishbone slave side and copperv
//             master side (see the interface file for the signal list)
//
//   Optional feature macro: WB_ERR_EN
//     Defined   : wb_err exists; a write response other than 1 completes the
//                 Wishbone cycle with a one-cycle wb_err instead of wb_ack.
//     Undefined : bus_w_resp is ignored and every completion acks.
//
//   Timing: all outputs come from registers or are decoded from the state
//   register alone, so there is no combinational input-to-output path. With a
//   target that is always ready, stb sampled in cycle 0 yields wb_ack in
//   cycle 3.
//
//   Abort: if wb_cyc drops while a transaction is in flight, the copperv side
//   still runs to completion (valids are never retracted), read data is still
//   captured, but the Wishbone completion pulse is suppressed.
module wb_to_bus_bridge #(
  parameter int unsigned addr_width   = 32,
  parameter int unsigned data_width   = 32,
  parameter int unsigned strobe_width = data_width / 8
) (
  input logic               clock,
  input logic               reset,
  wb_to_bus_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRaddr,
    StRdata,
    StWreq,
    StWresp,
    StAck
  } state_e;

  state_e                  state_q, state_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [data_width-1:0]   wdata_q, wdata_d;
  logic [strobe_width-1:0] sel_q, sel_d;
  logic [data_width-1:0]   rdata_q, rdata_d;
  // Set once wb_cyc has been seen low during the current transaction; the
  // completion pulse is then skipped even if wb_cyc comes back.
  logic                    abort_q, abort_d;
  logic                    done_abort;

`ifdef WB_ERR_EN
  // Completion kind for the ACK state: 1 = signal wb_err instead of wb_ack.
  logic                    err_q, err_d;
`else
  logic                    unused_resp;
  assign unused_resp = ^bus.bus_w_resp;
`endif

  // The transaction is treated as aborted if wb_cyc is low now or was low at
  // any earlier cycle of it.
  assign done_abort = abort_q || !bus.wb_cyc;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
`ifdef WB_ERR_EN
    err_d   = err_q;
`endif

    if (state_q != StIdle && state_q != StAck && !bus.wb_cyc) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
`ifdef WB_ERR_EN
        err_d   = 1'b0;
`endif
        // stb may be a single-cycle pulse: everything needed is latched here.
        if (bus.wb_cyc && bus.wb_stb) begin
          addr_d  = bus.wb_adr;
          wdata_d = bus.wb_datwr;
          sel_d   = bus.wb_sel;
          state_d = bus.wb_we ? StWreq : StRaddr;
        end
      end

      StRaddr: begin
        if (bus.bus_r_addr_ready) begin
          state_d = StRdata;
        end
      end

      StRdata: begin
        if (bus.bus_r_data_valid) begin
          // Captured even on abort so wb_datrd reflects the completed read.
          rdata_d = bus.bus_r_data;
          state_d = done_abort ? StIdle : StAck;
        end
      end

      StWreq: begin
        if (bus.bus_w_data_addr_ready) begin
          state_d = StWresp;
        end
      end

      StWresp: begin
        if (bus.bus_w_resp_valid) begin
`ifdef WB_ERR_EN
          err_d   = (bus.bus_w_resp != 1);
`endif
          state_d = done_abort ? StIdle : StAck;
        end
      end

      StAck: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
`ifdef WB_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
`ifdef WB_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Handshake outputs are pure state decodes; payloads come straight from the
  // request registers, so they are stable for the whole request phase.
  assign bus.bus_r_addr_valid      = (state_q == StRaddr);
  assign bus.bus_r_data_ready      = (state_q == StRdata);
  assign bus.bus_w_data_addr_valid = (state_q == StWreq);
  assign bus.bus_w_resp_ready      = (state_q == StWresp);

  assign bus.bus_r_addr   = addr_q;
  assign bus.bus_w_addr   = addr_q;
  assign bus.bus_w_data   = wdata_q;
  assign bus.bus_w_strobe = sel_q;
  assign bus.wb_datrd     = rdata_q;

`ifdef WB_ERR_EN
  assign bus.wb_ack = (state_q == StAck) && !err_q;
  assign bus.wb_err = (state_q == StAck) && err_q;
`else
  assign bus.wb_ack = (state_q == StAck);
`endif

endmodule

// File: tb/tb_wb_to_bus_bridge.sv
`timescale 1ns/1ps
module tb_wb_to_bus_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned RW = 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  wb_to_bus_bridge_if #(
    .addr_width  (AW),
    .data_width  (DW),
    .strobe_width(SW),
    .resp_width  (RW)
  ) bif ();

  wb_to_bus_bridge #(
    .addr_width  (AW),
    .data_width  (DW),
    .strobe_width(SW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bif)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cycle_n = 0;
  int ack_seen = 0;
  int err_seen = 0;

  // Transaction-level model: what the outputs must show, set by the stimulus
  // tasks from the request they issue and the responses the target gives.
  logic          exp_ack = 1'b0;
  logic          exp_err = 1'b0;
  logic          exp_busy = 1'b0;
  logic          exp_we = 1'b0;
  logic [31:0]   exp_addr = '0;
  logic [31:0]   exp_wdata = '0;
  logic [3:0]    exp_sel = '0;
  logic [31:0]   exp_datrd = '0;
  logic [31:0]   mem [logic [31:0]];

  always @(posedge clock) cycle_n <= cycle_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cycle_n);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    if (!reset) begin
      check("wb_ack", 64'(bif.wb_ack), 64'(exp_ack));
      if (bif.wb_ack) ack_seen++;
`ifdef WB_ERR_EN
      check("wb_err", 64'(bif.wb_err), 64'(exp_err));
      if (bif.wb_err) err_seen++;
`endif
      check("wb_datrd", 64'(bif.wb_datrd), 64'(exp_datrd));
      if (!exp_busy)
        check("idle_handshakes", 64'({bif.bus_r_addr_valid, bif.bus_r_data_ready,
              bif.bus_w_data_addr_valid, bif.bus_w_resp_ready}), 64'(0));
      if (bif.bus_r_addr_valid) begin
        check("read_is_expected", 64'(exp_we), 64'(0));
        check("bus_r_addr", 64'(bif.bus_r_addr), 64'(exp_addr));
      end
      if (bif.bus_w_data_addr_valid) begin
        check("write_is_expected", 64'(exp_we), 64'(1));
        check("bus_w_addr", 64'(bif.bus_w_addr), 64'(exp_addr));
        check("bus_w_data", 64'(bif.bus_w_data), 64'(exp_wdata));
        check("bus_w_strobe", 64'(bif.bus_w_strobe), 64'(exp_sel));
      end
    end
  end

  task automatic clear_inputs();
    bif.wb_cyc = 1'b0;
    bif.wb_stb = 1'b0;
    bif.wb_we = 1'b0;
    bif.wb_adr = '0;
    bif.wb_datwr = '0;
    bif.wb_sel = '0;
    bif.bus_r_addr_ready = 1'b0;
    bif.bus_r_data_valid = 1'b0;
    bif.bus_r_data = '0;
    bif.bus_w_data_addr_ready = 1'b0;
    bif.bus_w_resp_valid = 1'b0;
    bif.bus_w_resp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    exp_busy = 1'b0;
    exp_datrd = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outputs_zero"}, 64'({bif.wb_ack, bif.bus_r_addr_valid, bif.bus_r_data_ready,
          bif.bus_w_data_addr_valid, bif.bus_w_resp_ready, bif.bus_w_strobe}), 64'(0));
    check({tag, "_wb_datrd_zero"}, 64'(bif.wb_datrd), 64'(0));
    check({tag, "_addrs_zero"}, {bif.bus_r_addr, bif.bus_w_addr}, 64'(0));
    check({tag, "_w_data_zero"}, 64'(bif.bus_w_data), 64'(0));
  endtask

  // One Wishbone transaction with a copperv target that stalls its request
  // ready for addr_stall cycles and its response for data_delay cycles.
  // lat = cycle of the completion pulse relative to the stb cycle.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int addr_stall, input int data_delay,
                     input logic resp, input bit abort, output int lat,
                     output logic [31:0] first_addr, output logic [3:0] first_strb);
    int start;
    int n;
    bit ok;
    logic valid;
    logic rdy;
    logic [31:0] rd;
    lat = -1;
    first_addr = '0;
    first_strb = '0;
    bif.wb_cyc = 1'b1;
    bif.wb_stb = 1'b1;
    bif.wb_we = we;
    bif.wb_adr = adr;
    bif.wb_datwr = dat;
    bif.wb_sel = sel;
    exp_we = we;
    exp_addr = adr;
    exp_wdata = dat;
    exp_sel = sel;
    exp_busy = 1'b1;
    start = cycle_n;
    step();
    // Scramble the Wishbone request so only the latched copy can be used.
    bif.wb_stb = 1'b0;
    bif.wb_we = ~we;
    bif.wb_adr = ~adr;
    bif.wb_datwr = ~dat;
    bif.wb_sel = ~sel;

    ok = 1'b0;
    n = 0;
    while (n < 20) begin
      valid = we ? bif.bus_w_data_addr_valid : bif.bus_r_addr_valid;
      check("request_valid_held", 64'(valid), 64'(1));
      if (n == 0) begin
        first_addr = we ? bif.bus_w_addr : bif.bus_r_addr;
        first_strb = bif.bus_w_strobe;
      end
      if (n >= addr_stall) begin
        if (we) bif.bus_w_data_addr_ready = 1'b1;
        else bif.bus_r_addr_ready = 1'b1;
        if (valid) begin
          ok = 1'b1;
          break;
        end
      end
      step();
      n++;
    end
    if (!ok) begin
      check("request_handshake_timeout", 64'(0), 64'(1));
      do_reset();
      return;
    end
    step();
    bif.bus_r_addr_ready = 1'b0;
    bif.bus_w_data_addr_ready = 1'b0;
    if (abort) bif.wb_cyc = 1'b0;

    rd = mem_rd(adr);
    ok = 1'b0;
    n = 0;
    while (n < 20) begin
      rdy = we ? bif.bus_w_resp_ready : bif.bus_r_data_ready;
      check("response_ready", 64'(rdy), 64'(1));
      if (n >= data_delay) begin
        if (we) begin
          bif.bus_w_resp_valid = 1'b1;
          bif.bus_w_resp = resp;
        end else begin
          bif.bus_r_data_valid = 1'b1;
          bif.bus_r_data = rd;
        end
        if (rdy) begin
          ok = 1'b1;
          break;
        end
      end
      step();
      n++;
    end
    if (!ok) begin
      check("response_handshake_timeout", 64'(0), 64'(1));
      do_reset();
      return;
    end
    step();
    bif.bus_r_data_valid = 1'b0;
    bif.bus_r_data = 32'h0BAD_0BAD;
    bif.bus_w_resp_valid = 1'b0;
    if (!we) begin
      exp_datrd = rd;
    end else begin
      for (int b = 0; b < 4; b++) if (sel[b]) rd[8*b +: 8] = dat[8*b +: 8];
      mem[adr] = rd;
    end
    if (!abort) begin
`ifdef WB_ERR_EN
      if (we && resp !== 1'b1) exp_err = 1'b1;
      else exp_ack = 1'b1;
`else
      exp_ack = 1'b1;
`endif
    end
    exp_busy = 1'b0;
    lat = cycle_n - start;
    step();
    exp_ack = 1'b0;
    exp_err = 1'b0;
    bif.wb_cyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int a0;
    int e0;
    logic [31:0] fa;
    logic [3:0] fs;

    clear_inputs();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_all_zero("reset");

    // Read with an always-ready target.
    mem[32'h100] = 32'hDEAD_BEEF;
    a0 = ack_seen;
    txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 1'b1, 1'b0, lat, fa, fs);
    check("read_latency", 64'(lat), 64'(3));
    check("read_addr_cycle1", 64'(fa), 64'(32'h100));
    check("read_datrd", 64'(bif.wb_datrd), 64'(32'hDEAD_BEEF));
    check("read_ack_count", 64'(ack_seen - a0), 64'(1));

    // Write with request and response stalls.
    a0 = ack_seen;
    txn(1'b1, 32'h20, 32'h1234_5678, 4'b0011, 4, 2, 1'b1, 1'b0, lat, fa, fs);
    check("write_latency", 64'(lat), 64'(9));
    check("write_strobe", 64'(fs), 64'(4'b0011));
    check("write_addr", 64'(fa), 64'(32'h20));
    check("write_ack_count", 64'(ack_seen - a0), 64'(1));
    check("model_masked_write", 64'(mem_rd(32'h20)), 64'(32'h0000_5678));
    check("write_keeps_datrd", 64'(bif.wb_datrd), 64'(32'hDEAD_BEEF));

    // Back-to-back write then read of the same location.
    a0 = ack_seen;
    txn(1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 0, 0, 1'b1, 1'b0, lat, fa, fs);
    check("b2b_write_latency", 64'(lat), 64'(3));
    txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 0, 1'b1, 1'b0, lat, fa, fs);
    check("b2b_read_latency", 64'(lat), 64'(3));
    check("b2b_read_data", 64'(bif.wb_datrd), 64'(32'hA5A5_A5A5));
    check("b2b_ack_count", 64'(ack_seen - a0), 64'(2));

    // Abort while waiting for read data.
    mem[32'h80] = 32'h55;
    a0 = ack_seen;
    txn(1'b0, 32'h80, 32'h0, 4'hF, 1, 1, 1'b1, 1'b1, lat, fa, fs);
    check("abort_no_ack", 64'(ack_seen - a0), 64'(0));
    check("abort_datrd", 64'(bif.wb_datrd), 64'(32'h55));
    txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 1'b1, 1'b0, lat, fa, fs);
    check("after_abort_latency", 64'(lat), 64'(3));
    check("after_abort_data", 64'(bif.wb_datrd), 64'(32'hDEAD_BEEF));

    // stb without cyc must not start anything.
    a0 = ack_seen;
    bif.wb_stb = 1'b1;
    bif.wb_adr = 32'h100;
    step();
    bif.wb_stb = 1'b0;
    repeat (4) step();
    check("stb_without_cyc", 64'(ack_seen - a0), 64'(0));

    // Reset while the write request is stalled.
    bif.wb_cyc = 1'b1;
    bif.wb_stb = 1'b1;
    bif.wb_we = 1'b1;
    bif.wb_adr = 32'h60;
    bif.wb_datwr = 32'h7777_7777;
    bif.wb_sel = 4'hF;
    exp_we = 1'b1;
    exp_addr = 32'h60;
    exp_wdata = 32'h7777_7777;
    exp_sel = 4'hF;
    exp_busy = 1'b1;
    step();
    bif.wb_stb = 1'b0;
    step();
    check("wreq_valid_before_reset", 64'(bif.bus_w_data_addr_valid), 64'(1));
    step();
    do_reset();
    check_all_zero("mid_reset");
    mem[32'h44] = 32'h0;
    a0 = ack_seen;
    txn(1'b1, 32'h44, 32'hCAFE_F00D, 4'b1100, 1, 0, 1'b1, 1'b0, lat, fa, fs);
    check("post_reset_write_latency", 64'(lat), 64'(4));
    txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 1'b1, 1'b0, lat, fa, fs);
    check("post_reset_readback", 64'(bif.wb_datrd), 64'(32'hCAFE_0000));
    check("post_reset_ack_count", 64'(ack_seen - a0), 64'(2));

    // Error response and OK response on writes.
    a0 = ack_seen;
    e0 = err_seen;
    txn(1'b1, 32'h48, 32'h1, 4'hF, 0, 0, 1'b0, 1'b0, lat, fa, fs);
`ifdef WB_ERR_EN
    check("bad_resp_err", 64'(err_seen - e0), 64'(1));
    check("bad_resp_no_ack", 64'(ack_seen - a0), 64'(0));
`else
    check("bad_resp_ignored_ack", 64'(ack_seen - a0), 64'(1));
    check("bad_resp_no_err", 64'(err_seen - e0), 64'(0));
`endif
    a0 = ack_seen;
    e0 = err_seen;
    txn(1'b1, 32'h48, 32'h2, 4'hF, 0, 0, 1'b1, 1'b0, lat, fa, fs);
    check("ok_resp_ack", 64'(ack_seen - a0), 64'(1));
    check("ok_resp_no_err", 64'(err_seen - e0), 64'(0));

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_to_bus_bridge.md
Name: wb_to_bus_bridge

Overview:
- Wishbone classic slave that converts Wishbone cycles into copperv split-bus transactions: read address/data channels and write data+address/response channels.
- Lets a Wishbone initiator (debug master, test harness, or an existing bus-to-Wishbone adapter) reach copperv-bus targets such as memories and peripherals.
- One outstanding transaction at a time.
- Sits between the Wishbone fabric and a copperv-bus target.

Parameters:
- addr_width, 32, width of wb_adr / bus_r_addr / bus_w_addr.
- data_width, 32, width of all data paths.
- strobe_width, data_width/8, byte-select width (wb_sel, bus_w_strobe).
- resp_width, 1, write response width; value 1 = OK.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- wb_adr  in  addr_width  Wishbone address
- wb_datwr  in  data_width  Wishbone write data
- wb_datrd  out  data_width  Wishbone read data, registered
- wb_we  in  1  1 = write
- wb_stb  in  1  strobe; may be a single-cycle pulse
- wb_cyc  in  1  cycle valid
- wb_sel  in  strobe_width  byte selects
- wb_ack  out  1  one-cycle completion pulse
- bus_r_addr_valid  out  1  read address valid
- bus_r_addr_ready  in  1  read address ready
- bus_r_addr  out  addr_width  read address
- bus_r_data_valid  in  1  read data valid
- bus_r_data_ready  out  1  read data ready
- bus_r_data  in  data_width  read data
- bus_w_data_addr_valid  out  1  write request valid
- bus_w_data_addr_ready  in  1  write request ready
- bus_w_data  out  data_width  write data
- bus_w_addr  out  addr_width  write address
- bus_w_strobe  out  strobe_width  write byte strobes
- bus_w_resp_valid  in  1  write response valid
- bus_w_resp_ready  out  1  write response ready
- bus_w_resp  in  resp_width  write response

Behaviour:
- Reset: synchronous, active-high; reset clock; state = IDLE.
  - Every output resets to 0: wb_ack, wb_datrd, all valid/ready outputs, bus_r_addr, bus_w_addr, bus_w_data, bus_w_strobe.
  - Reset mid-transaction abandons the transaction: no ack, all bus valids drop on the next edge.
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP, ACK. All outputs registered or decoded from state only; no combinational in-to-out paths.
- IDLE:
  - wb_cyc && wb_stb sampled high → latch wb_adr, wb_datwr, wb_sel, wb_we.
  - Go to RADDR if we=0, WREQ if we=1.
  - The single-cycle stb pulse is captured; stb need not be held.
- RADDR: bus_r_addr_valid=1, bus_r_addr=latched address. On valid&&ready → RDATA.
- RDATA: bus_r_data_ready=1. On bus_r_data_valid → wb_datrd<=bus_r_data, go to ACK.
- WREQ: bus_w_data_addr_valid=1; bus_w_addr/data/strobe = latched values. On valid&&ready → WRESP.
- WRESP: bus_w_resp_ready=1. On bus_w_resp_valid → ACK. bus_w_resp is ignored unless WB_ERR_EN is defined.
- ACK: wb_ack=1 for exactly one cycle, then IDLE. A new request is accepted no earlier than the cycle after ACK.
- Valid outputs stay high and payloads stay stable until the handshake completes (no retraction).
- Minimum latency: stb at cycle 0, with ready/valid returned immediately → wb_ack high in cycle 3, for both reads and writes.
- wb_datrd holds the last read data until the next read completes; writes do not alter it.
- wb_cyc deasserted mid-transaction (abort):
  - Bus-side transaction still completes, keeping handshakes legal.
  - ACK state is skipped (no wb_ack); return to IDLE.
  - Read data is still captured into wb_datrd.
- wb_stb with wb_cyc=0 is ignored.
- Requests arriving while not in IDLE are ignored; the initiator must wait for ack.

Optional Feature:
- Macro WB_ERR_EN.
- Defined:
  - Adds output port wb_err (1 bit, reset 0).
  - In WRESP, if bus_w_resp != 1, pulse wb_err for one cycle in place of wb_ack.
  - Reads always ack.
  - Abort rules apply to wb_err identically.
- Undefined: no wb_err port; bus_w_resp is ignored and every completion acks.

Test Plan:
- Read, target always ready: stb pulse, adr=0x100; bus_r_data=0xDEADBEEF valid immediately → bus_r_addr=0x100 in cycle 1, wb_ack in cycle 3, wb_datrd=0xDEADBEEF.
- Write with stalls: adr=0x20, datwr=0x12345678, sel=4'b0011; ready held low 4 cycles, resp 2 cycles later → valid held with stable payload; bus_w_strobe=0011; exactly one wb_ack after resp.
- Back-to-back: write 0xA5A5A5A5 to 0x40, then read 0x40 from a memory model → read returns 0xA5A5A5A5; each transaction acks exactly once.
- Abort: wb_cyc dropped while in RDATA with data 0x55 → no wb_ack; wb_datrd=0x55; FSM returns to IDLE; next read completes normally.
- Reset during WREQ → all outputs 0 the next cycle; a subsequent write completes.
- WB_ERR_EN defined, bus_w_resp=0 → wb_err pulses one cycle, wb_ack stays 0; bus_w_resp=1 → wb_ack pulses, wb_err stays 0.
